// File: rtl/ws_array_ctrl_pkg.sv
// Shared types and width helpers for the weight-stationary array sequencer.
package ws_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StLoadW   = 2'd1,
        StCompute = 2'd2,
        StDone    = 2'd3
    } ws_state_e;

    // Never returns 0 so a degenerate parameter still yields a legal vector.
    function automatic int unsigned w_clog2(input int unsigned v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

    function automatic int unsigned t_cycles(input int unsigned rows, input int unsigned cols,
                                             input int unsigned len);
        return len + rows + cols - 1;
    endfunction

    function automatic int unsigned row_w(input int unsigned rows);
        return w_clog2(rows);
    endfunction

    function automatic int unsigned waddr_w(input int unsigned max_passes,
                                            input int unsigned rows);
        return w_clog2(max_passes * rows);
    endfunction

    function automatic int unsigned iaddr_w(input int unsigned max_passes,
                                            input int unsigned len);
        return w_clog2(max_passes * len);
    endfunction

    function automatic int unsigned paddr_w(input int unsigned len);
        return w_clog2(len);
    endfunction

    function automatic int unsigned pass_w(input int unsigned max_passes);
        return w_clog2(max_passes);
    endfunction

    function automatic int unsigned npass_w(input int unsigned max_passes);
        return w_clog2(max_passes + 1);
    endfunction

    function automatic int unsigned ccnt_w(input int unsigned rows, input int unsigned cols,
                                           input int unsigned len);
        return w_clog2(t_cycles(rows, cols, len));
    endfunction

endpackage

// File: rtl/ws_array_ctrl_if.sv
// Control/buffer bus of ws_array_ctrl; perf counters exist only under WS_ARRAY_CTRL_PERF_EN.
interface ws_array_ctrl_if #(
    parameter int unsigned ROWS       = 3,
    parameter int unsigned COLS       = 3,
    parameter int unsigned IACT_LEN   = 16,
    parameter int unsigned MAX_PASSES = 4
);
    import ws_ctrl_pkg::*;

    localparam int unsigned RW  = row_w(ROWS);
    localparam int unsigned WAW = waddr_w(MAX_PASSES, ROWS);
    localparam int unsigned IAW = iaddr_w(MAX_PASSES, IACT_LEN);
    localparam int unsigned PAW = paddr_w(IACT_LEN);
    localparam int unsigned PW  = pass_w(MAX_PASSES);
    localparam int unsigned NPW = npass_w(MAX_PASSES);

    logic           go;
    logic [NPW-1:0] num_passes;
    logic           stall;
    logic           busy;
    logic           done;
    logic           array_en;
    logic           weight_load;
    logic [RW-1:0]  weight_row;
    logic [WAW-1:0] weight_addr;
    logic [ROWS-1:0] load_iact;
    logic [IAW-1:0] iact_addr [ROWS];
    logic [COLS-1:0] psum_valid;
    logic [PAW-1:0] psum_addr [COLS];
    logic           psum_accum;
    logic [PW-1:0]  pass_idx;
`ifdef WS_ARRAY_CTRL_PERF_EN
    logic [31:0]    perf_busy_cycles;
    logic [31:0]    perf_stall_cycles;
`endif

    modport master (
        input  go, num_passes, stall,
        output busy, done, array_en, weight_load, weight_row, weight_addr,
        output load_iact, iact_addr, psum_valid, psum_addr, psum_accum, pass_idx
`ifdef WS_ARRAY_CTRL_PERF_EN
        , output perf_busy_cycles, perf_stall_cycles
`endif
    );

    modport slave (
        output go, num_passes, stall,
        input  busy, done, array_en, weight_load, weight_row, weight_addr,
        input  load_iact, iact_addr, psum_valid, psum_addr, psum_accum, pass_idx
`ifdef WS_ARRAY_CTRL_PERF_EN
        , input perf_busy_cycles, perf_stall_cycles
`endif
    );

endinterface

// File: rtl/ws_lane_window.sv
// Decodes whether a row/column lane is active for a COMPUTE count and its local index.
module ws_lane_window #(
    parameter int unsigned OFFSET = 0,
    parameter int unsigned LEN    = 16,
    parameter int unsigned CW     = 5,
    parameter int unsigned IW     = 4
) (
    input  logic [CW-1:0] ccnt,
    output logic          active,
    output logic [IW-1:0] idx
);
    logic [31:0] w_rel;

    // Counts below OFFSET wrap to a huge value, so one compare covers both bounds.
    assign w_rel  = 32'(ccnt) - 32'(OFFSET);
    assign active = (w_rel < LEN);
    assign idx    = active ? IW'(w_rel) : '0;

endmodule

// File: rtl/ws_array_ctrl.sv
// Multi-pass weight-stationary array sequencer; WS_ARRAY_CTRL_PERF_EN adds perf counters.
module ws_array_ctrl
    import ws_ctrl_pkg::*;
#(
    parameter int unsigned ROWS       = 3,
    parameter int unsigned COLS       = 3,
    parameter int unsigned IACT_LEN   = 16,
    parameter int unsigned MAX_PASSES = 4
) (
    input  logic           clk,
    input  logic           rstn,
    ws_array_ctrl_if.master bus
);
    localparam int unsigned RW  = row_w(ROWS);
    localparam int unsigned WAW = waddr_w(MAX_PASSES, ROWS);
    localparam int unsigned IAW = iaddr_w(MAX_PASSES, IACT_LEN);
    localparam int unsigned PAW = paddr_w(IACT_LEN);
    localparam int unsigned PW  = pass_w(MAX_PASSES);
    localparam int unsigned NPW = npass_w(MAX_PASSES);
    localparam int unsigned T   = t_cycles(ROWS, COLS, IACT_LEN);
    localparam int unsigned CW  = ccnt_w(ROWS, COLS, IACT_LEN);

    ws_state_e      r_state, w_state_nxt;
    logic [RW-1:0]  r_wcnt, w_wcnt_nxt;
    logic [CW-1:0]  r_ccnt, w_ccnt_nxt;
    logic [PW-1:0]  r_pass, w_pass_nxt;
    logic [NPW-1:0] r_npass, w_npass_nxt;
    logic [NPW-1:0] w_np_clamp;

    logic w_in_load, w_in_comp, w_busy;
    logic [ROWS-1:0] w_row_act;
    logic [PAW-1:0]  w_row_idx [ROWS];
    logic [COLS-1:0] w_col_act;
    logic [PAW-1:0]  w_col_idx [COLS];

    assign w_np_clamp = (32'(bus.num_passes) > MAX_PASSES) ? NPW'(MAX_PASSES) : bus.num_passes;

    always_comb begin
        w_state_nxt = r_state;
        w_wcnt_nxt  = r_wcnt;
        w_ccnt_nxt  = r_ccnt;
        w_pass_nxt  = r_pass;
        w_npass_nxt = r_npass;
        unique case (r_state)
            StIdle: begin
                if (bus.go) begin
                    w_pass_nxt  = '0;
                    w_wcnt_nxt  = '0;
                    w_ccnt_nxt  = '0;
                    w_npass_nxt = w_np_clamp;
                    w_state_nxt = (w_np_clamp == '0) ? StDone : StLoadW;
                end
            end
            StLoadW: begin
                if (!bus.stall) begin
                    if (32'(r_wcnt) == ROWS - 1) begin
                        w_wcnt_nxt  = '0;
                        w_ccnt_nxt  = '0;
                        w_state_nxt = StCompute;
                    end else begin
                        w_wcnt_nxt = r_wcnt + 1'b1;
                    end
                end
            end
            StCompute: begin
                if (!bus.stall) begin
                    if (32'(r_ccnt) == T - 1) begin
                        w_ccnt_nxt = '0;
                        if (32'(r_pass) + 1 < 32'(r_npass)) begin
                            w_pass_nxt  = r_pass + 1'b1;
                            w_state_nxt = StLoadW;
                        end else begin
                            // Clearing the pass here keeps pass_idx/psum_accum low once idle.
                            w_pass_nxt  = '0;
                            w_state_nxt = StDone;
                        end
                    end else begin
                        w_ccnt_nxt = r_ccnt + 1'b1;
                    end
                end
            end
            StDone:  w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= StIdle;
            r_wcnt  <= '0;
            r_ccnt  <= '0;
            r_pass  <= '0;
            r_npass <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wcnt  <= w_wcnt_nxt;
            r_ccnt  <= w_ccnt_nxt;
            r_pass  <= w_pass_nxt;
            r_npass <= w_npass_nxt;
        end
    end

    assign w_in_load = (r_state == StLoadW);
    assign w_in_comp = (r_state == StCompute);
    assign w_busy    = (r_state != StIdle);

    assign bus.busy        = w_busy;
    assign bus.done        = (r_state == StDone);
    assign bus.array_en    = (w_in_load || w_in_comp) && !bus.stall;
    assign bus.weight_load = w_in_load && !bus.stall;
    assign bus.weight_row  = w_in_load ? r_wcnt : '0;
    assign bus.weight_addr = w_in_load ? WAW'(32'(r_pass) * ROWS + 32'(r_wcnt)) : '0;
    assign bus.psum_accum  = (w_in_load || w_in_comp) && (r_pass != '0);
    assign bus.pass_idx    = r_pass;

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        ws_lane_window #(
            .OFFSET (r),
            .LEN    (IACT_LEN),
            .CW     (CW),
            .IW     (PAW)
        ) u_win (
            .ccnt   (r_ccnt),
            .active (w_row_act[r]),
            .idx    (w_row_idx[r])
        );
        assign bus.load_iact[r] = w_in_comp && w_row_act[r] && !bus.stall;
        assign bus.iact_addr[r] = (w_in_comp && w_row_act[r]) ?
                                  IAW'(32'(r_pass) * IACT_LEN + 32'(w_row_idx[r])) : '0;
    end

    for (genvar c = 0; c < COLS; c++) begin : g_col
        ws_lane_window #(
            .OFFSET (ROWS + c),
            .LEN    (IACT_LEN),
            .CW     (CW),
            .IW     (PAW)
        ) u_win (
            .ccnt   (r_ccnt),
            .active (w_col_act[c]),
            .idx    (w_col_idx[c])
        );
        assign bus.psum_valid[c] = w_in_comp && w_col_act[c] && !bus.stall;
        assign bus.psum_addr[c]  = (w_in_comp && w_col_act[c]) ? w_col_idx[c] : '0;
    end

`ifdef WS_ARRAY_CTRL_PERF_EN
    logic [31:0] r_perf_busy, r_perf_stall;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_perf_busy  <= '0;
            r_perf_stall <= '0;
        end else if (r_state == StIdle && bus.go) begin
            r_perf_busy  <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_busy && r_perf_busy != '1) r_perf_busy <= r_perf_busy + 1'b1;
            if (w_busy && bus.stall && r_perf_stall != '1) r_perf_stall <= r_perf_stall + 1'b1;
        end
    end

    assign bus.perf_busy_cycles  = r_perf_busy;
    assign bus.perf_stall_cycles = r_perf_stall;
`endif

endmodule

// File: doc/ws_array_ctrl.md
# ws_array_ctrl

Parametrised sequencer for an ROWS×COLS weight-stationary PE array with multi-pass input-channel accumulation. Per pass, one weight row per cycle is loaded into the array, row-skewed iact streams are issued, and per-column psum write strobes and addresses are generated. Supports memory back-pressure through a global stall. It replaces the fixed 3×3 single-pass controller between the top-level go/done handshake and the weight, iact and psum buffers.

## Interface
- ROWS, 3, PE array rows; one weight word is one row of COLS weights.
- COLS, 3, PE array columns.
- IACT_LEN, 16, iact vectors streamed per pass.
- MAX_PASSES, 4, maximum passes (input-channel tiles) per job.
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- go  in  1  start pulse; ignored while busy.
- num_passes  in  $clog2(MAX_PASSES+1)  passes per job; sampled on accepted go.
- stall  in  1  freeze request from the buffers.
- busy  out  1  high from the first LOAD_W cycle through the DONE cycle.
- done  out  1  one-cycle completion pulse.
- array_en  out  1  PE pipeline enable: (LOAD_W or COMPUTE) and !stall.
- weight_load  out  1  weight row write strobe.
- weight_row  out  $clog2(ROWS)  target PE row.
- weight_addr  out  $clog2(MAX_PASSES*ROWS)  pass*ROWS + row.
- load_iact  out  [ROWS]  per-row iact strobe.
- iact_addr  out  [ROWS][$clog2(MAX_PASSES*IACT_LEN)]  pass*IACT_LEN + idx.
- psum_valid  out  [COLS]  per-column psum strobe.
- psum_addr  out  [COLS][$clog2(IACT_LEN)]  output vector index.
- psum_accum  out  1  high when pass_idx > 0; buffer adds instead of overwriting.
- pass_idx  out  $clog2(MAX_PASSES)  current pass.

## Operation
- States: IDLE, LOAD_W, COMPUTE, DONE.
- IDLE + go → LOAD_W, with pass 0 and wcnt 0. num_passes is latched and values above MAX_PASSES are clamped to MAX_PASSES. If num_passes is 0, go → DONE directly and no strobes are issued.
- LOAD_W, wcnt 0..ROWS-1:
  - weight_load = 1.
  - weight_row = wcnt.
  - At wcnt = ROWS-1 → COMPUTE with ccnt 0.
- COMPUTE, ccnt 0..T-1, where T = IACT_LEN+ROWS+COLS-1:
  - Row r: load_iact[r] = 1 when r ≤ ccnt < r+IACT_LEN; idx = ccnt-r.
  - Column c: psum_valid[c] = 1 when ROWS+c ≤ ccnt < ROWS+c+IACT_LEN; psum_addr[c] = ccnt-ROWS-c.
  - All inactive addresses drive 0.
- At ccnt = T-1: if pass < latched-1, pass++ and → LOAD_W; otherwise → DONE.
- DONE: done = 1 for one cycle, then → IDLE.
- Stall: while stall = 1 in LOAD_W or COMPUTE:
  - State and all counters hold.
  - weight_load, load_iact and psum_valid are forced to 0.
  - Addresses hold their values.
  - stall has no effect in IDLE or DONE.
- go in any state other than IDLE is ignored.
- Reset, including mid-job: immediately returns to IDLE with all counters at 0 and every output at 0.

## Timing
- Moore machine: every output is decoded from registered state and counters. There is no combinational path from go or num_passes to any output.
- stall gates the strobes and array_en combinationally in the same cycle.
- go accepted in cycle 0 → first weight_load in cycle 1.
- Unstalled pass duration: ROWS + T cycles.
- Unstalled job: done asserts in cycle 1 + P·(ROWS+T), where P is the clamped num_passes. A new go is accepted in the cycle after done.

## Configuration
- Macro: WS_ARRAY_CTRL_PERF_EN.
- With the macro defined, two extra outputs are added:
  - perf_busy_cycles  out  32  counts cycles with busy = 1.
  - perf_stall_cycles  out  32  counts cycles with busy and stall both 1.
  - Both counters saturate at all-ones, clear on an accepted go, reset to 0, and hold their value after done.
- Without the macro, these ports and counters do not exist and all other behaviour is identical.

## Structure
- Package ws_ctrl_pkg holds:
  - The state enum typedef.
  - The width helpers (weight, iact, psum address and pass-index widths).
  - The T computation.
- Sub-module ws_lane_window, instantiated once per row and once per column:
  - Parameters: OFFSET, LEN.
  - Input: ccnt. Outputs: active and idx.
  - Purely combinational.

## Test plan
All scenarios use ROWS=3, COLS=3, IACT_LEN=4, MAX_PASSES=4, so T=9.
- Single pass: go at cycle 0 with num_passes=1 → the following responses, with busy high in cycles 1–13:
  - weight_load in cycles 1–3 with weight_addr 0,1,2.
  - load_iact[0] in cycles 4–7 with addr 0–3.
  - load_iact[2] in cycles 6–9.
  - psum_valid[0] in cycles 7–10 with psum_addr 0–3.
  - psum_valid[2] in cycles 9–12.
  - done in cycle 13.
- Two passes: num_passes=2 → the following responses:
  - Second LOAD_W in cycles 13–15 with weight_addr 3,4,5.
  - iact_addr[0] 4–7.
  - psum_accum=1 while psum_addr repeats 0–3.
  - done in cycle 25.
- Stall: stall=1 in cycle 8 of the single-pass case → all strobes are 0 and array_en=0 in cycle 8, the remaining sequence shifts by 1, and done asserts in cycle 14. With the PERF macro, perf_stall_cycles=1 and perf_busy_cycles=14.
- Boundary inputs:
  - num_passes=0 → done in cycle 1 with no strobes.
  - num_passes=7 → clamped to 4, and done in cycle 49.
- Mid-job control:
  - go during COMPUTE → ignored.
  - rstn low in cycle 6 → all outputs 0 immediately.
  - After release, a new go restarts from pass 0 with weight_addr 0.
